// File: rtl/stream_demux_n.sv
// Purpose: registered 1-to-N valid/ready demux with unicast/broadcast routing and drop counting.
// Latency: an accepted beat appears on out_valid/out_data exactly one cycle later.
// Backpressure: in_ready follows the free state of the targeted slot(s); drops always accept.
module stream_demux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      bcast,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          drop_cnt
);

  // One holding slot per channel; packed so slice k lands at bits [k*WIDTH +: WIDTH].
  logic [CHANNELS-1:0]            full;
  logic [CHANNELS-1:0][WIDTH-1:0] data_q;

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] uni_hit;
  logic [CHANNELS-1:0] tgt;
  logic [CHANNELS-1:0] load;
  logic [31:0]         sel_ext;
  logic                has_tgt;
  logic                accept;
  logic                drop;

  assign sel_ext   = 32'(in_sel);
  assign free      = ~full | out_ready;
  assign out_valid = full;
  assign out_data  = data_q;

  // Resolve the target set; out-of-range selects match no channel and fall onto the drop path.
  always_comb begin
    uni_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_ext == 32'(k)) uni_hit[k] = 1'b1;
    end
    tgt     = bcast ? en_mask : (uni_hit & en_mask);
    has_tgt = (tgt != '0);
    // All-or-nothing: every target must be free; independent of in_valid.
    in_ready = has_tgt ? &(~tgt | free) : 1'b1;
    accept   = in_valid && in_ready;
    load     = accept ? tgt : '0;
    drop     = accept && !has_tgt;
  end

  // Slot update: a load wins over a pop, so pop+reload keeps the slot full with the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= '0;
      data_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          full[k]   <= 1'b1;
          data_q[k] <= in_data;
        end else if (out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        bcast = 1'b0;
  logic [3:0]  en_mask = 4'hF;
  logic [3:0]  out_ready = 4'h0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  // Second instance with a 2-bit counter for saturation.
  logic        in_ready2;
  logic [3:0]  out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  drop_cnt2;

  // Non-power-of-two instance for out-of-range selects.
  logic [2:0]  in_sel5 = '0;
  logic [4:0]  en_mask5 = 5'h1F;
  logic [4:0]  out_ready5 = 5'h1F;
  logic        in_ready5;
  logic [4:0]  out_valid5;
  logic [39:0] out_data5;
  logic [7:0]  drop_cnt5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .bcast(bcast), .en_mask(en_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt));

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_sel(in_sel), .bcast(bcast), .en_mask(en_mask), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .drop_cnt(drop_cnt2));

  stream_demux_n #(.WIDTH(8), .CHANNELS(5), .CNT_W(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
    .in_sel(in_sel5), .bcast(1'b0), .en_mask(en_mask5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_data(out_data5), .drop_cnt(drop_cnt5));

  typedef struct {
    logic        v;
    logic        bc;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic [3:0]  ordy;
    logic [7:0]  d;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic bc, input logic [1:0] sel,
                       input logic [3:0] en, input logic [3:0] ordy, input logic [7:0] d);
    in_valid  = v;
    bcast     = bc;
    in_sel    = sel;
    en_mask   = en;
    out_ready = ordy;
    in_data   = d;
  endtask

  // Inputs change 1 after a rising edge; in_ready is sampled 3 after; outputs 1 after the next edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 8'hA0, 1'b1, 4'b0001, 32'h000000A0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 4'hF, 4'hF, 8'hA1, 1'b1, 4'b0010, 32'h0000A1A0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 4'hF, 4'hF, 8'hA2, 1'b1, 4'b0100, 32'h00A2A1A0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 2'd3, 4'hF, 4'hF, 8'hA3, 1'b1, 4'b1000, 32'hA3A2A1A0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 8'h00, 1'b1, 4'b0000, 32'hA3A2A1A0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 2'd1, 4'hF, 4'hD, 8'h11, 1'b1, 4'b0010, 32'hA3A211A0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, 4'hF, 4'hD, 8'h22, 1'b0, 4'b0010, 32'hA3A211A0, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 2'd3, 4'hF, 4'hD, 8'h33, 1'b1, 4'b1010, 32'h33A211A0, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 2'd1, 4'hF, 4'hF, 8'h22, 1'b1, 4'b0010, 32'h33A222A0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 8'h00, 1'b1, 4'b0000, 32'h33A222A0, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 8'h01, 1'b1, 4'b0001, 32'h33A22201, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 8'h02, 1'b1, 4'b0001, 32'h33A22202, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 8'h00, 1'b1, 4'b0000, 32'h33A22202, 8'd0};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 4'hE, 4'h0, 8'hEE, 1'b1, 4'b0000, 32'h33A22202, 8'd1};

    // Reset mid-stream with ch2 holding a beat.
    #1;
    do_reset();
    drive(1'b1, 1'b0, 2'd2, 4'hF, 4'h0, 8'h99);
    tick();
    chk("pre_reset_full2", 64'(out_valid), 64'h4);
    drive(1'b1, 1'b0, 2'd3, 4'hF, 4'h0, 8'h98);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    drive(1'b0, 1'b0, 2'd2, 4'hF, 4'h0, 8'h00);
    tick();
    rst = 1'b0;
    #2;
    chk("post_reset_ready", 64'(in_ready), 64'h1);
    tick();
    chk("post_reset_idle", 64'(out_valid), 64'h0);

    // Table: unicast sweep, backpressure isolation, pop/reload, disabled-channel drop.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].bc, tbl[i].sel, tbl[i].en, tbl[i].ordy, tbl[i].d);
      #2;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].exp_od));
      chk($sformatf("vec%0d_drop_cnt", i), 64'(drop_cnt), 64'(tbl[i].exp_cnt));
    end

    // Broadcast blocked by a stalled enabled channel, then released.
    drive(1'b1, 1'b0, 2'd3, 4'hF, 4'h0, 8'h77);
    tick();
    chk("bc_ch3_full", 64'(out_valid), 64'h8);
    drive(1'b1, 1'b1, 2'd0, 4'b1011, 4'h0, 8'h5C);
    #2;
    chk("bc_blocked_ready", 64'(in_ready), 64'h0);
    tick();
    chk("bc_blocked_valid", 64'(out_valid), 64'h8);
    chk("bc_blocked_data", 64'(out_data), 64'h77A22202);
    drive(1'b1, 1'b1, 2'd0, 4'b1011, 4'b1000, 8'h5C);
    #2;
    chk("bc_release_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bc_deliver_valid", 64'(out_valid), 64'hB);
    chk("bc_deliver_data", 64'(out_data), 64'h5CA25C5C);
    drive(1'b1, 1'b1, 2'd0, 4'h0, 4'hF, 8'h5C);
    #2;
    chk("bc_nomask_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bc_nomask_valid", 64'(out_valid), 64'h0);
    chk("bc_nomask_drop", 64'(drop_cnt), 64'h2);

    // Drops: all disabled, counter saturation, out-of-range selects on the 5-channel instance.
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 8'h00);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'(i), 4'h0, 4'hF, 8'(8'hD0 + i));
      in_sel5 = (i % 2 == 0) ? 3'd6 : 3'd7;
      tick();
    end
    chk("drop3_cnt", 64'(drop_cnt), 64'h3);
    chk("drop3_cnt2", 64'(drop_cnt2), 64'h3);
    chk("drop3_cnt5", 64'(drop_cnt5), 64'h3);
    chk("drop3_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 2'(i), 4'h0, 4'hF, 8'h0F);
      in_sel5 = 3'd5;
      tick();
    end
    chk("drop5_cnt", 64'(drop_cnt), 64'h5);
    chk("drop5_cnt2_sat", 64'(drop_cnt2), 64'h3);
    chk("drop5_cnt5", 64'(drop_cnt5), 64'h5);
    chk("drop5_valid5", 64'(out_valid5), 64'h0);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'hF, 8'h4D);
    in_sel5 = 3'd4;
    #2;
    chk("ch4_ready5", 64'(in_ready5), 64'h1);
    tick();
    chk("ch4_valid5", 64'(out_valid5), 64'h10);
    chk("ch4_data5", 64'(out_data5[39:32]), 64'h4D);
    chk("ch4_cnt5", 64'(drop_cnt5), 64'h5);
    chk("ch4_cnt_main", 64'(drop_cnt), 64'h6);
    drive(1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered 1-to-N demultiplexer for valid/ready streams. It supersedes the combinational 1-to-2 and 1-to-4 demux trees.
- A single input stream is routed to one of CHANNELS output channels, selected per beat. A broadcast mode copies the beat to all enabled channels.
- Beats aimed at disabled or out-of-range channels are dropped and counted.
- Sits between a single producer and N independent consumers. Each consumer may stall on its own without losing data.

Parameters:
- WIDTH, 8, data bits per beat.
- CHANNELS, 4, number of output channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), select width. Derived; do not override.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_W  destination channel; used in unicast only.
- bcast  input  1  1 = broadcast the beat to all enabled channels; 0 = unicast.
- en_mask  input  CHANNELS  per-channel enable; bit k enables channel k.
- out_valid  output  CHANNELS  bit k: channel k holds a beat.
- out_ready  input  CHANNELS  bit k: consumer k takes the beat.
- out_data  output  CHANNELS*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
- drop_cnt  output  CNT_W  saturating count of dropped beats.

Behaviour:
- Storage: one slot per channel, made of full[k] and data[k]. out_valid[k] = full[k]; out_data slice k = data[k].
- Reset (async, rst=1): all full[k]=0, all data[k]=0, drop_cnt=0. A beat in flight at reset is lost. On the first edge after release, in_ready reflects empty slots.
- free[k] = !full[k] || out_ready[k]. A slot may be popped and reloaded in the same cycle.
- in_ready (combinational; must not depend on in_valid):
  - Unicast, in_sel < CHANNELS and en_mask[in_sel]=1: in_ready = free[in_sel].
  - Unicast, in_sel >= CHANNELS or en_mask[in_sel]=0: in_ready=1 (drop path).
  - Broadcast, en_mask != 0: in_ready = AND over k of (!en_mask[k] || free[k]). Broadcast is all-or-nothing; no partial delivery.
  - Broadcast, en_mask = 0: in_ready=1 (drop path).
- Accept = in_valid && in_ready. bcast, in_sel and en_mask are sampled only on the accept cycle.
- On accept with targets: for each target k, data[k] <= in_data and full[k] <= 1.
- On accept on the drop path: no slot changes; drop_cnt increments by 1, saturating at 2^CNT_W-1. It never wraps.
- Pop: out_valid[k] && out_ready[k] with no load to k that cycle gives full[k] <= 0. data[k] holds its last value.
- Simultaneous pop and load on the same k: full[k] stays 1 and data[k] takes the new beat.
- Latency: an accepted beat appears on out_valid/out_data exactly 1 cycle later. Throughput is 1 beat/cycle per channel when out_ready is held high.
- A stalled channel never blocks other channels in unicast. It does block broadcast until it frees, if it is enabled.
- out_valid[k]/data[k] must stay stable while out_valid[k]=1 and out_ready[k]=0.
- Changing en_mask never clears or alters beats already stored.
- Combinational path from out_ready to in_ready is permitted. There is no path from in_valid to in_ready.
- Illegal/unused: in_sel values >= CHANNELS when CHANNELS is not a power of 2. These are treated as disabled (drop path), never as an alias.

Test Plan:
- Reset/idle: assert rst mid-stream with full[2]=1 → out_valid=0000, drop_cnt=0, out_data all 0. After release, in_ready=1 for sel=2, en_mask=1111.
- Unicast sweep: en_mask=1111, out_ready=1111; send data 0xA0..0xA3 with sel 0..3, one per cycle → out_valid one-hot 0001,0010,0100,1000 on the following cycles, with the matching data. in_ready stays 1 throughout.
- Backpressure isolation: out_ready[1]=0; send sel=1 data 0x11, then sel=1 data 0x22, then sel=3 data 0x33 → 0x11 held on ch1. in_ready=0 for the second beat until out_ready[1]=1. The sel=3 beat is still accepted and delivered. 0x22 appears in the cycle after ch1 pops.
- Broadcast: en_mask=1011, bcast=1, data 0x5C, out_ready[3]=0 with ch3 full → in_ready=0. Release out_ready[3] → ch0, ch1 and ch3 each get 0x5C one cycle after accept. ch2 stays empty.
- Drops: en_mask=0000, send 3 unicast beats → drop_cnt=3, no out_valid. Then CNT_W=2 config, send 5 drops → drop_cnt saturates at 3.
- Same-cycle pop/reload: ch0 full with 0x01, out_ready[0]=1; accept sel=0 data 0x02 in the same cycle → next cycle out_valid[0]=1 with data 0x02. No bubble and no lost beat.
